// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline-stage register with a valid/ready handshake
// and a 2-entry skid buffer (main = head, skid = overflow slot).
// in_ready comes straight from a flop, so downstream backpressure never forms
// a combinational path back upstream. The ctrl and tag fields are gated by
// valid, so a bubble can never carry write enables or a destination tag.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to add a saturating 16-bit
// stall_cnt output. It counts cycles where out_valid & !out_ready.
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // Registered state
  logic              main_v_r;
  logic              skid_v_r;
  logic              in_ready_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [TAG_W-1:0]  main_tag_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [TAG_W-1:0]  skid_tag_r;
  logic [DATA_W-1:0] skid_data_r;

  // Next-state values
  logic              main_v_s;
  logic              skid_v_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [TAG_W-1:0]  main_tag_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [TAG_W-1:0]  skid_tag_s;
  logic [DATA_W-1:0] skid_data_s;

  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_v_r & out_ready;

  // Outputs come directly from the head register. ctrl and tag are gated by valid.
  assign in_ready  = in_ready_r;
  assign out_valid = main_v_r;
  assign out_ctrl  = main_ctrl_r & {CTRL_W{main_v_r}};
  assign out_tag   = main_tag_r & {TAG_W{main_v_r}};
  assign out_data  = main_data_r;

  // Next-state logic for the {main_v, skid_v} occupancy state and both entries.
  always_comb begin
    main_v_s    = main_v_r;
    skid_v_s    = skid_v_r;
    main_ctrl_s = main_ctrl_r;
    main_tag_s  = main_tag_r;
    main_data_s = main_data_r;
    skid_ctrl_s = skid_ctrl_r;
    skid_tag_s  = skid_tag_r;
    skid_data_s = skid_data_r;
    if (flush) begin
      // Squash everything, including any coincident input. Data is left as it was.
      main_v_s    = 1'b0;
      skid_v_s    = 1'b0;
      main_ctrl_s = {CTRL_W{1'b0}};
      main_tag_s  = {TAG_W{1'b0}};
      skid_ctrl_s = {CTRL_W{1'b0}};
      skid_tag_s  = {TAG_W{1'b0}};
    end else begin
      case ({main_v_r, skid_v_r})
        2'b00: begin
          if (in_fire_s) begin
            main_v_s    = 1'b1;
            main_ctrl_s = in_ctrl;
            main_tag_s  = in_tag;
            main_data_s = in_data;
          end else begin
            main_v_s = 1'b0;
          end
        end
        2'b10: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_s = in_ctrl;
            main_tag_s  = in_tag;
            main_data_s = in_data;
          end else if (in_fire_s) begin
            skid_v_s    = 1'b1;
            skid_ctrl_s = in_ctrl;
            skid_tag_s  = in_tag;
            skid_data_s = in_data;
          end else if (out_fire_s) begin
            main_v_s    = 1'b0;
            main_ctrl_s = {CTRL_W{1'b0}};
            main_tag_s  = {TAG_W{1'b0}};
          end else begin
            main_v_s = 1'b1;
          end
        end
        2'b11: begin
          // in_ready is low here, so only the drain of the head can happen.
          if (out_fire_s) begin
            skid_v_s    = 1'b0;
            main_ctrl_s = skid_ctrl_r;
            main_tag_s  = skid_tag_r;
            main_data_s = skid_data_r;
            skid_ctrl_s = {CTRL_W{1'b0}};
            skid_tag_s  = {TAG_W{1'b0}};
          end else begin
            skid_v_s = 1'b1;
          end
        end
        default: begin
          // An orphan skid entry is unreachable, so recover to EMPTY.
          main_v_s    = 1'b0;
          skid_v_s    = 1'b0;
          main_ctrl_s = {CTRL_W{1'b0}};
          main_tag_s  = {TAG_W{1'b0}};
          skid_ctrl_s = {CTRL_W{1'b0}};
          skid_tag_s  = {TAG_W{1'b0}};
        end
      endcase
    end
  end

  // State and payload registers. in_ready is registered as the complement of the next skid_v.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_r    <= 1'b0;
      skid_v_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_tag_r  <= {TAG_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_tag_r  <= {TAG_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
    end else begin
      main_v_r    <= main_v_s;
      skid_v_r    <= skid_v_s;
      in_ready_r  <= ~skid_v_s;
      main_ctrl_r <= main_ctrl_s;
      main_tag_r  <= main_tag_s;
      main_data_r <= main_data_s;
      skid_ctrl_r <= skid_ctrl_s;
      skid_tag_r  <= skid_tag_s;
      skid_data_r <= skid_data_s;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating count of cycles in which the head is stalled by downstream. Flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (main_v_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic.
// The reference is a FIFO queue of accepted entries with at most two resident.
module tb_pipe_skid_reg;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   s0;
`endif

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_tag(out_tag), .out_data(out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    int            vis;
  } ent_t;

  ent_t exp_q[$];
  int   npass  = 0;
  int   ntotal = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ntotal++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Drive one cycle of inputs just after the rising edge. An accepted entry
  // is queued and becomes visible at the head one cycle later.
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [TW-1:0] t,
                       input logic [DW-1:0] d, input logic ordy, input logic fl,
                       output logic acc);
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    in_valid  = v;
    in_ctrl   = c;
    in_tag    = t;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = v && !fl && (exp_q.size() < 2);
    if (acc) begin
      e.c = c; e.t = t; e.d = d; e.vis = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drv(input logic v, input logic [CW-1:0] c, input logic [TW-1:0] t,
                     input logic [DW-1:0] d, input logic ordy, input logic fl);
    logic a;
    drive(v, c, t, d, ordy, fl, a);
  endtask

  // Monitor: compare the DUT head against the reference queue on every falling edge.
  always @(negedge clk) begin
    int nv;
    if (mon_en) begin
      nv = 0;
      foreach (exp_q[i]) if (exp_q[i].vis <= cyc) nv++;
      check("in_ready", {63'd0, in_ready}, {63'd0, (nv < 2)});
      check("out_valid", {63'd0, out_valid}, {63'd0, (nv > 0)});
      if (nv > 0) begin
        check("out_ctrl", {62'd0, out_ctrl}, {62'd0, exp_q[0].c});
        check("out_tag", {59'd0, out_tag}, {59'd0, exp_q[0].t});
        check("out_data", out_data, exp_q[0].d);
      end else begin
        check("bubble_ctrl", {62'd0, out_ctrl}, 64'd0);
        check("bubble_tag", {59'd0, out_tag}, 64'd0);
      end
      if (flush) exp_q.delete();
      else if (nv > 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic          pv;
    logic          acc;
    logic          fl;
    logic [CW-1:0] pc;
    logic [TW-1:0] pt;
    logic [DW-1:0] pd;

    // Reset held with traffic presented
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD;
    in_ctrl = 2'b11; in_tag = 5'd7; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_ctrl", {62'd0, out_ctrl}, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1; in_valid = 1'b0; mon_en = 1'b1;

    // First transfer after reset
    drv(1'b1, 2'b11, 5'd7, 64'h55, 1'b1, 1'b0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_ctrl", {62'd0, out_ctrl}, 64'd3);
    check("first_tag", {59'd0, out_tag}, 64'd7);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

    // Streaming 1..8 back to back
    for (int i = 1; i <= 8; i++) drv(1'b1, 2'(i), 5'(i), 64'(i), 1'b1, 1'b0);
    repeat (3) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

    // Skid: A then B under backpressure
    drv(1'b1, 2'b01, 5'd10, 64'd10, 1'b0, 1'b0);
    drv(1'b1, 2'b10, 5'd11, 64'd11, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("skid_in_ready", {63'd0, in_ready}, 64'd0);
    check("skid_hold_data", out_data, 64'd10);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("skid_second", out_data, 64'd11);
    check("skid_ready_back", {63'd0, in_ready}, 64'd1);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

    // Flush while TWO, with input 99 offered
    drv(1'b1, 2'b11, 5'd20, 64'd20, 1'b0, 1'b0);
    drv(1'b1, 2'b11, 5'd21, 64'd21, 1'b0, 1'b0);
    drv(1'b1, 2'b11, 5'd31, 64'd99, 1'b0, 1'b1);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ctrl", {62'd0, out_ctrl}, 64'd0);
    check("flush_tag", {59'd0, out_tag}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush in ONE with a coincident accepted input: the input is dropped
    drv(1'b1, 2'b01, 5'd3, 64'd40, 1'b0, 1'b0);
    drv(1'b1, 2'b11, 5'd31, 64'd99, 1'b1, 1'b1);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush1_valid", {63'd0, out_valid}, 64'd0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

    // Random traffic; an offered entry is held until accepted or flushed
    pv = 1'b0; pc = 2'b00; pt = 5'd0; pd = 64'd0;
    for (int i = 0; i < 600; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pc = 2'($urandom);
        pt = 5'($urandom);
        pd = {$urandom, $urandom};
      end
      fl = ($urandom_range(0, 19) == 0);
      drive(pv, pc, pt, pd, ($urandom_range(0, 2) != 0), fl, acc);
      if (acc || fl) pv = 1'b0;
    end
    repeat (4) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges while TWO
    drv(1'b1, 2'b01, 5'd5, 64'd50, 1'b0, 1'b0);
    drv(1'b1, 2'b10, 5'd6, 64'd51, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ctrl", {62'd0, out_ctrl}, 64'd0);
    check("arst_tag", {59'd0, out_tag}, 64'd0);
    check("arst_data", out_data, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    drv(1'b1, 2'b10, 5'd9, 64'h77, 1'b1, 1'b0);
    repeat (2) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STALL_CNT_EN
    // Stall counter: 5 stalled cycles, then saturation
    drv(1'b1, 2'b01, 5'd1, 64'd1, 1'b0, 1'b0);
    drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    s0 = stall_cnt;
    repeat (5) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_5", {48'd0, 16'(stall_cnt - s0)}, 64'd5);
    repeat (70000) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    repeat (2) drv(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field MEM/WB latch group: one generic pipeline-stage register for all stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a 2-entry skid buffer, so backpressure does not need a combinational stall path through the stage.
- A control sub-field is forced to zero whenever the stage holds a bubble. Bubbles therefore can never write the register file or memory.
- Used by instantiating once per boundary with the concatenated field width.

Parameters:
- DATA_W, 64: width of the non-control payload (e.g. ALU output + mem output = 64 for MEM/WB).
- CTRL_W, 2: width of the control field that is gated by valid (e.g. WB_ctrl).
- TAG_W, 5: width of the destination-register tag (RegFwd). Zeroed with ctrl on bubble.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle (registered)
- in_ctrl  in  CTRL_W  control field
- in_tag  in  TAG_W  destination tag
- in_data  in  DATA_W  payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control, 0 when !out_valid
- out_tag  out  TAG_W  head tag, 0 when !out_valid
- out_data  out  DATA_W  head payload, holds last value when !out_valid

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Protocol rule: upstream must not drop in_valid or change payload while in_valid & !in_ready. The block does not check this.
- Storage: main register (head) and skid register. State is encoded by main_v and skid_v.
  - EMPTY (0,0)
  - ONE (1,0)
  - TWO (1,1)
  - (0,1) is illegal.
- in_ready = !skid_v, driven directly from a flop. No combinational path from out_ready to in_ready.
- out_valid = main_v. out_* come directly from the main register; ctrl and tag are ANDed with main_v.
- Transitions when flush = 0:
  - EMPTY + in_fire -> ONE; main loads input.
  - ONE + in_fire + out_fire -> ONE; main loads input.
  - ONE + in_fire + !out_fire -> TWO; skid loads input, main holds.
  - ONE + !in_fire + out_fire -> EMPTY.
  - TWO + out_fire -> ONE; main loads skid, skid_v cleared. in_fire cannot occur in TWO because in_ready = 0.
  - Any state with no fire: hold.
- Latency and ordering:
  - Latency in to out is 1 cycle when EMPTY.
  - Sustained throughput is 1 entry/cycle while out_ready = 1.
  - Order is strictly FIFO.
- Flush (highest priority):
  - Next state is EMPTY; main_v and skid_v cleared.
  - Stored ctrl and tag cleared; stored data holds.
  - A coincident in_fire is discarded.
  - in_ready is 1 the cycle after a flush.
- Reset (rst = 0, asynchronous):
  - main_v, skid_v, all ctrl/tag/data flops cleared.
  - Hence out_valid = 0, out_ctrl = 0, out_tag = 0, out_data = 0, in_ready = 1.
  - Reset asserted mid-transfer drops both entries immediately.
  - Release is synchronous to the next clk edge in normal integration; the block needs no extra sync.
- Width rules: no arithmetic; all fields pass through bit-exact.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt (16 bits).
  - stall_cnt increments each cycle with out_valid & !out_ready, saturating at 16'hFFFF.
  - It clears on reset only; flush does not clear it.
- When undefined:
  - Port and counter are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst = 0 with in_valid = 1, in_data = 64'hDEAD -> out_valid = 0, out_ctrl = 0, out_tag = 0, out_data = 0, in_ready = 1. Release, then one in_fire with ctrl = 2'b11, tag = 5'd7 -> out_valid = 1, out_ctrl = 3, out_tag = 7 next cycle.
- Streaming: out_ready = 1, 8 back-to-back inputs data = 1..8 -> outputs 1..8 on consecutive cycles, in_ready stays 1.
- Skid: send A = 10; drop out_ready; send B = 11 -> state TWO, in_ready = 0 next cycle, out_data = 10 held. Raise out_ready -> 10 then 11 on successive cycles, in_ready returns to 1.
- Flush in TWO: flush = 1 with in_valid = 1, data = 99 -> next cycle out_valid = 0, out_ctrl = 0, out_tag = 0, in_ready = 1; the 99 entry never appears.
- Async reset mid-stream: pulse rst = 0 between clock edges while in TWO -> outputs clear immediately without waiting for clk.
- With PIPE_SKID_STALL_CNT_EN: hold out_valid = 1, out_ready = 0 for 5 cycles -> stall_cnt = 5. Force 70000 stall cycles -> stall_cnt = 16'hFFFF.
